// File: rtl/othello_pkg.sv
// Shared types for the Othello flip-mask datapath: board words, line directions, sequencer states.
package othello_pkg;

  typedef logic [63:0] board_t;

  typedef enum logic [1:0] {DIR_ROW, DIR_COL, DIR_DIAG, DIR_ANTI} dir_e;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} seq_state_e;

  function automatic logic [6:0] popcount64(input board_t b);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + {6'd0, b[i]};
    return c;
  endfunction

endpackage

// File: rtl/board_line_mux.sv
// Board <-> line mapping for one direction: extracts player/opponent lines around pos and scatters a line
// result back to a 64-bit mask. Purely combinational; off-board line bits read 0 and are dropped on scatter.
module board_line_mux
  import othello_pkg::*;
(
  input  board_t     board_p,
  input  board_t     board_o,
  input  logic [5:0] pos,
  input  dir_e       dir,
  input  logic [7:0] line,
  output logic [7:0] line_p,
  output logic [7:0] line_o,
  output logic [2:0] line_pos,
  output board_t     mask
);

  int rk;
  int fl;
  int sq;

  always_comb begin
    line_p   = '0;
    line_o   = '0;
    mask     = '0;
    line_pos = (dir == DIR_COL) ? pos[5:3] : pos[2:0];
    rk       = 0;
    fl       = 0;
    sq       = 0;
    for (int i = 0; i < 8; i++) begin
      case (dir)
        DIR_ROW:  begin rk = int'(pos[5:3]);                   fl = i;              end
        DIR_COL:  begin rk = i;                                fl = int'(pos[2:0]); end
        DIR_DIAG: begin rk = int'(pos[5:3]) - int'(pos[2:0]) + i; fl = i;           end
        default:  begin rk = int'(pos[5:3]) + int'(pos[2:0]) - i; fl = i;           end
      endcase
      if (rk >= 0 && rk < 8) begin
        sq             = rk * 8 + fl;
        line_p[i]      = board_p[sq[5:0]];
        line_o[i]      = board_o[sq[5:0]];
        mask[sq[5:0]]  = line[i];
      end
    end
  end

endmodule

// File: rtl/flip8.sv
// Single-line Othello flip unit: stones flipped along one 8-square line, both directions from line_pos.
// Latency LAT cycles, fully pipelined, no stall; validity is tracked by the caller.
module flip8 #(
  parameter int LAT = 2
) (
  input  logic       clock,
  input  logic [7:0] line_player,
  input  logic [7:0] line_opponent,
  input  logic [2:0] line_pos,
  output logic [7:0] flip
);

  logic [7:0] res;
  logic [7:0] run;
  logic       hit;
  logic       stop;
  int         idx;

  // A run of opponent stones counts only if it is capped by a player stone on the line.
  always_comb begin
    res  = '0;
    idx  = 0;
    run  = '0;
    hit  = 1'b0;
    stop = 1'b0;
    for (int k = 1; k < 8; k++) begin
      idx = int'(line_pos) + k;
      if (!stop && idx < 8) begin
        if (line_opponent[idx[2:0]]) run[idx[2:0]] = 1'b1;
        else begin
          stop = 1'b1;
          hit  = line_player[idx[2:0]];
        end
      end
    end
    if (hit) res = res | run;

    run  = '0;
    hit  = 1'b0;
    stop = 1'b0;
    for (int k = 1; k < 8; k++) begin
      idx = int'(line_pos) - k;
      if (!stop && idx >= 0) begin
        if (line_opponent[idx[2:0]]) run[idx[2:0]] = 1'b1;
        else begin
          stop = 1'b1;
          hit  = line_player[idx[2:0]];
        end
      end
    end
    if (hit) res = res | run;
  end

  logic [7:0] stage [LAT];

  always_ff @(posedge clock) begin
    stage[0] <= res;
    for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
  end

  assign flip = stage[LAT-1];

endmodule

// File: rtl/flip_board_sequencer.sv
// Full-board flip mask for one move by running row/col/diag/anti lines through one shared flip8.
// Latency 4+FLIP_LAT+1 accept-to-out_valid; one request in flight; FLIP_SEQ_COUNT_EN adds flip_count.
module flip_board_sequencer
  import othello_pkg::*;
#(
  parameter int FLIP_LAT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  board_t     player,
  input  board_t     opponent,
  input  logic [5:0] pos,
  output logic       out_valid,
  input  logic       out_ready,
  output board_t     flip
`ifdef FLIP_SEQ_COUNT_EN
  ,
  output logic [6:0] flip_count
`endif
);

  seq_state_e          state;
  board_t              p_q;
  board_t              o_q;
  board_t              acc;
  logic [5:0]          pos_q;
  dir_e                dir_cnt;
  logic [FLIP_LAT-1:0] tag_vld;
  dir_e                tag_dir [FLIP_LAT];

  logic [7:0] ext_p;
  logic [7:0] ext_o;
  logic [2:0] ext_pos;
  logic [7:0] flip8_res;
  board_t     sc_mask;
  board_t     unused_ext_mask;
  logic [7:0] unused_sc_line_p;
  logic [7:0] unused_sc_line_o;
  logic [2:0] unused_sc_line_pos;

  board_line_mux u_extract (
    .board_p (p_q),
    .board_o (o_q),
    .pos     (pos_q),
    .dir     (dir_cnt),
    .line    (8'h00),
    .line_p  (ext_p),
    .line_o  (ext_o),
    .line_pos(ext_pos),
    .mask    (unused_ext_mask)
  );

  flip8 #(.LAT(FLIP_LAT)) u_flip8 (
    .clock        (clock),
    .line_player  (ext_p),
    .line_opponent(ext_o),
    .line_pos     (ext_pos),
    .flip         (flip8_res)
  );

  board_line_mux u_scatter (
    .board_p ('0),
    .board_o ('0),
    .pos     (pos_q),
    .dir     (tag_dir[FLIP_LAT-1]),
    .line    (flip8_res),
    .line_p  (unused_sc_line_p),
    .line_o  (unused_sc_line_o),
    .line_pos(unused_sc_line_pos),
    .mask    (sc_mask)
  );

  // Tags shadow the flip8 pipeline; clearing them on reset discards in-flight results.
  always_ff @(posedge clock) begin
    if (reset) tag_vld <= '0;
    else begin
      tag_vld[0] <= (state == ISSUE);
      for (int i = 1; i < FLIP_LAT; i++) tag_vld[i] <= tag_vld[i-1];
    end
  end

  always_ff @(posedge clock) begin
    tag_dir[0] <= dir_cnt;
    for (int i = 1; i < FLIP_LAT; i++) tag_dir[i] <= tag_dir[i-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      flip      <= '0;
      acc       <= '0;
      p_q       <= '0;
      o_q       <= '0;
      pos_q     <= '0;
      dir_cnt   <= DIR_ROW;
`ifdef FLIP_SEQ_COUNT_EN
      flip_count <= '0;
`endif
    end else begin
      if (tag_vld[FLIP_LAT-1]) acc <= acc | sc_mask;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            p_q      <= player;
            o_q      <= opponent;
            pos_q    <= pos;
            acc      <= '0;
            dir_cnt  <= DIR_ROW;
            in_ready <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          dir_cnt <= dir_e'(dir_cnt + 2'd1);
          if (dir_cnt == DIR_ANTI) state <= DRAIN;
        end
        DRAIN: begin
          if (tag_vld == '0) begin
            flip      <= acc;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef FLIP_SEQ_COUNT_EN
            flip_count <= popcount64(acc);
`endif
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flip_board_sequencer.sv
// Vector table plus scoreboard for flip_board_sequencer, checked against an 8-direction ray-walk model.
module tb_flip_board_sequencer;
  import othello_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  board_t     player;
  board_t     opponent;
  logic [5:0] pos;
  logic       out_valid;
  logic       out_ready;
  board_t     flip;
`ifdef FLIP_SEQ_COUNT_EN
  logic [6:0] flip_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  board_t exp_q[$];

  typedef struct {
    board_t     p;
    board_t     o;
    logic [5:0] ps;
    board_t     exp;
    int         hold;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  always #5 clock = ~clock;

  flip_board_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .player   (player),
    .opponent (opponent),
    .pos      (pos),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .flip     (flip)
`ifdef FLIP_SEQ_COUNT_EN
    ,
    .flip_count(flip_count)
`endif
  );

  function automatic board_t ref_flip(input board_t p, input board_t o, input logic [5:0] ps);
    board_t res;
    board_t run;
    int r;
    int f;
    res = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int df = -1; df <= 1; df++) begin
        if (dr != 0 || df != 0) begin
          run = '0;
          r = int'(ps[5:3]) + dr;
          f = int'(ps[2:0]) + df;
          while (r >= 0 && r < 8 && f >= 0 && f < 8 && o[r*8+f]) begin
            run[r*8+f] = 1'b1;
            r += dr;
            f += df;
          end
          if (r >= 0 && r < 8 && f >= 0 && f < 8 && p[r*8+f]) res |= run;
        end
      end
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input board_t p, input board_t o, input logic [5:0] ps, input board_t exp);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    player   = p;
    opponent = o;
    pos      = ps;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int n;
    board_t exp;
    board_t f0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("latency", n, 7);
    check("in_ready_busy", in_ready, 0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check("flip", flip, exp);
`ifdef FLIP_SEQ_COUNT_EN
    check("flip_count", flip_count, $countones(exp));
`endif
    f0 = flip;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_valid", out_valid, 1);
      check("hold_flip", flip, f0);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    board_t rp;
    board_t ro;
    logic [5:0] rps;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    player    = '0;
    opponent  = '0;
    pos       = '0;

    vecs[0] = '{64'h1,  64'h2,    6'd2,  64'h2,    0};
    vecs[1] = '{64'h1,  64'h100,  6'd16, 64'h100,  5};
    vecs[2] = '{64'h1,  64'h200,  6'd18, 64'h200,  0};
    vecs[3] = '{64'h80, 64'h4000, 6'd21, 64'h4000, 0};
    vecs[4] = '{64'h0100, 64'h80, 6'd6,  64'h0,    0};
    vecs[5] = '{64'h8000000081, 64'h00040000004200, 6'd27,
                ref_flip(64'h8000000081, 64'h00040000004200, 6'd27), 0};
    vecs[6] = '{64'h1, 64'h7E, 6'd7, 64'h7E, 0};
    vecs[7] = '{64'h8100000000000081, 64'h0042240000244200, 6'd27,
                ref_flip(64'h8100000000000081, 64'h0042240000244200, 6'd27), 2};
    for (int i = 8; i < NVEC; i++) begin
      rp  = {$urandom, $urandom} & {$urandom, $urandom};
      ro  = {$urandom, $urandom} & ~rp;
      rps = 6'($urandom_range(0, 63));
      vecs[i] = '{rp, ro, rps, ref_flip(rp, ro, rps), 0};
    end

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_flip", flip, 0);
`ifdef FLIP_SEQ_COUNT_EN
    check("reset_flip_count", flip_count, 0);
`endif

    for (int i = 0; i < NVEC; i++) begin
      send(vecs[i].p, vecs[i].o, vecs[i].ps, vecs[i].exp);
      collect(vecs[i].hold);
    end

    // Abort a row-flipping request in its 2nd ISSUE cycle, then check the next result is clean.
    send(64'h1, 64'h7E, 6'd7, 64'h7E);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    exp_q.delete();
    send(64'h0100, 64'h80, 6'd6, 64'h0);
    collect(0);
    send(64'h1, 64'h200, 6'd18, 64'h200);
    collect(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
